outport: RTL and testbench

- Return path of the MAC datapath: converts a 28-bit unsigned fixed-point accumulator result back to an 8-bit unsigned integer.
- The input fixed-point format is the one produced by the input aligner: int8 placed at bit offset s, with s selected by a 3-bit mode.
- Right-shifts by the same mode-selected offset, rounds, and saturates to 8 bits.
- Registered 2-stage pipeline with valid/ready handshake on both sides, plus a saturation event counter. Sits between the accumulator and the result write-back.

---
 rtl/outport.sv | 99 +++++++++
 tb/tb_outport.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/outport.sv
// Return path of the MAC datapath: 28-bit unsigned fixed-point accumulator -> uint8 with
// mode-selected right shift, optional round-half-up (OUTPORT_ROUND_EN) and saturation.
module outport #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [27:0]      acc,
    input  logic [2:0]       outport_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       int8,
    output logic             sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    localparam int ACC_W = 28;
    localparam int SUM_W = 29;
    localparam int T_W   = 23;

    logic             en;
    logic [2:0]       s_p0;
    logic [SUM_W-1:0] sum_p0;
    logic [SUM_W-1:0] shifted_p0;
    logic [T_W-1:0]   t_p1;
    logic             vld_p1;

    function automatic logic [2:0] shift_sel(input logic [2:0] mode);
        logic [2:0] s;
        case (mode)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: s = mode;
            default:                      s = 3'd6;
        endcase
        return s;
    endfunction

`ifdef OUTPORT_ROUND_EN
    function automatic logic [SUM_W-1:0] round_bias(input logic [2:0] s);
        return SUM_W'(1) << (s - 3'd1);
    endfunction
`endif

    // With s = 1 the shifted value can reach 28 bits; anything that does not fit the
    // 23-bit stage register is pinned to all-ones so it still saturates downstream.
    function automatic logic [T_W-1:0] clamp_t(input logic [SUM_W-1:0] v);
        return (|v[SUM_W-1:T_W]) ? {T_W{1'b1}} : v[T_W-1:0];
    endfunction

    function automatic logic is_sat(input logic [T_W-1:0] t);
        return t > T_W'(255);
    endfunction

    function automatic logic [7:0] sat_u8(input logic [T_W-1:0] t);
        return is_sat(t) ? 8'hFF : t[7:0];
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign s_p0 = shift_sel(outport_mode);
`ifdef OUTPORT_ROUND_EN
    assign sum_p0 = {1'b0, acc} + round_bias(s_p0);
`else
    assign sum_p0 = SUM_W'(acc);
`endif
    assign shifted_p0 = sum_p0 >> s_p0;

    // ---- stage 1: shifted value / stage 2: saturated result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            t_p1      <= '0;
            out_valid <= 1'b0;
            int8      <= '0;
            sat       <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                t_p1 <= clamp_t(shifted_p0);
            end
            out_valid <= vld_p1;
            int8      <= sat_u8(t_p1);
            sat       <= vld_p1 && is_sat(t_p1);
        end
    end

    // Clear wins over a same-cycle saturated transfer; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && sat && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_outport.sv
// Directed table-driven bench for outport; expected values follow OUTPORT_ROUND_EN.
module tb_outport;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] acc;
    logic [2:0]  outport_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  int8;
    logic        sat;
    logic [2:0]  sat_cnt;
    logic        sat_clr;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    outport #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .acc(acc),
        .outport_mode(outport_mode), .out_valid(out_valid), .out_ready(out_ready),
        .int8(int8), .sat(sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] acc;
        logic [2:0]  mode;
        logic [7:0]  exp_int8;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated item with out_ready high: checked 2 cycles after transfer, then drained.
    task automatic send_one(input string name, input logic [27:0] a, input logic [2:0] m,
                            input logic [7:0] e8, input logic es);
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        acc          = a;
        outport_mode = m;
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_int8"}, 32'(int8), 32'(e8));
        check({name, "_sat"}, 32'(sat), 32'(es));
        tick();
        if (es && exp_cnt < 7) exp_cnt++;
        check({name, "_drain"}, 32'(out_valid), 32'd0);
        check({name, "_cnt"}, 32'(sat_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] held_val;
        logic       held;
        logic       acc_now;
        int         sent;
        int         recv;

        vecs[0]  = '{28'h1FC0, 3'd6, 8'd127, 1'b0};
`ifdef OUTPORT_ROUND_EN
        vecs[1]  = '{28'h1FE0, 3'd6, 8'd128, 1'b0};
        vecs[2]  = '{28'h3,    3'd1, 8'd2,   1'b0};
        vecs[15] = '{28'h3FE,  3'd2, 8'd255, 1'b1};
`else
        vecs[1]  = '{28'h1FE0, 3'd6, 8'd127, 1'b0};
        vecs[2]  = '{28'h3,    3'd1, 8'd1,   1'b0};
        vecs[15] = '{28'h3FE,  3'd2, 8'd255, 1'b0};
`endif
        vecs[3]  = '{28'hA80,  3'd0, 8'd42,  1'b0};
        vecs[4]  = '{28'h54,   3'd1, 8'd42,  1'b0};
        vecs[5]  = '{28'hA8,   3'd2, 8'd42,  1'b0};
        vecs[6]  = '{28'h150,  3'd3, 8'd42,  1'b0};
        vecs[7]  = '{28'h2A0,  3'd4, 8'd42,  1'b0};
        vecs[8]  = '{28'h540,  3'd5, 8'd42,  1'b0};
        vecs[9]  = '{28'hA80,  3'd6, 8'd42,  1'b0};
        vecs[10] = '{28'hA80,  3'd7, 8'd42,  1'b0};
        vecs[11] = '{28'hFFFFFFF, 3'd1, 8'd255, 1'b1};
        vecs[12] = '{28'h3FC0, 3'd6, 8'd255, 1'b0};
        vecs[13] = '{28'h0,    3'd3, 8'd0,   1'b0};
        vecs[14] = '{28'hFFFFFFF, 3'd7, 8'd255, 1'b1};
        vecs[16] = '{28'h100,  3'd0, 8'd4,   1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        acc = '0; outport_mode = '0;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_int8", 32'(int8), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i].acc, vecs[i].mode,
                     vecs[i].exp_int8, vecs[i].exp_sat);
        end

        // Clear coinciding with a saturated output transfer.
        out_ready = 1'b1; in_valid = 1'b1; acc = 28'hFFFFFFF; outport_mode = 3'd1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_sat", 32'(sat), 32'd1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        exp_cnt = 0;
        check("clr_cnt", 32'(sat_cnt), 32'd0);

        // Back-to-back stream with stalls; values k*10 for k = 1..8.
        sent = 0; recv = 0; held = 1'b0; held_val = '0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(int8), 32'(held_val));
            end
            out_ready    = (c >= 3 && c <= 5) ? 1'b0 :
                           (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid     = (sent < 8);
            acc          = 28'((sent + 1) * 10) << 6;
            outport_mode = 3'd6;
            #1;
            check("in_ready_en", 32'(in_ready), 32'(!out_valid || out_ready));
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("stream_order", 32'(int8), 32'((recv + 1) * 10));
                recv++;
            end
            held     = out_valid && !out_ready;
            held_val = int8;
            @(posedge clk);
            #1;
            if (acc_now) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'd8);
        repeat (3) begin
            tick();
            check("stream_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with two saturated items in flight.
        in_valid = 1'b1; acc = 28'hFFFFFFF; outport_mode = 3'd1;
        tick();
        outport_mode = 3'd7;
        tick();
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_int8", 32'(int8), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        check("mid_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            tick();
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Counter sticks at all-ones (CNT_W = 3).
        for (int i = 0; i < 8; i++) begin
            send_one($sformatf("cap%0d", i), 28'hFFFFFFF, 3'd2, 8'd255, 1'b1);
        end
        check("cnt_all_ones", 32'(sat_cnt), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
